// File: rtl/jpeg_byte_stuffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_byte_stuffer_if
//  Description : Word-in / byte-out stream bundle for the JPEG byte stuffer.
//                The master drives words and accepts bytes, and the slave
//                (the stuffer) does the reverse.
//  Revision    : 1.0  initial release
// ============================================================================
interface jpeg_byte_stuffer_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        in_last;
   logic [4:0]  in_last_bits;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_last;

   modport master (
      output in_valid, in_data, in_last, in_last_bits, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );

   modport slave (
      input  in_valid, in_data, in_last, in_last_bits, out_ready,
      output in_ready, out_valid, out_data, out_last
   );
endinterface
`default_nettype wire

// File: rtl/jpeg_byte_stuffer.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_byte_stuffer
//  Description : Serialises 32-bit MSB-first entropy-coded words into bytes.
//                It inserts a 0x00 after every 0xFF data byte, truncates and
//                1-pads the final word, and optionally appends the EOI marker.
//  Revision    : 1.0  initial release
// ============================================================================
module jpeg_byte_stuffer #(
   parameter int EMIT_EOI = 1,
   parameter int CNT_W    = 24
) (
   input  wire logic              clk,
   input  wire logic              rst,
   jpeg_byte_stuffer_if.slave     bus,
   output logic [CNT_W-1:0]       byte_count,
   output logic                   frame_done,
   output logic                   busy
);

   localparam logic c_emit_eoi = (EMIT_EOI != 0);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DATA   = 3'd1,
      S_STUFF  = 3'd2,
      S_EOI_FF = 3'd3,
      S_EOI_D9 = 3'd4
   } state_t;

   state_t           r_state;
   logic [31:0]      r_buf;
   logic             r_last;
   logic [2:0]       r_nbytes;
   logic             r_in_ready;
   logic             r_out_valid;
   logic [7:0]       r_out_data;
   logic             r_out_last;
   logic [CNT_W-1:0] r_cnt;
   logic             r_reload;
   logic             r_frame_done;

   // Capture-side decode: bit count (0 means a full word), pad mask, byte count.
   logic [5:0]  w_nbits;
   logic [5:0]  w_nbits_rnd;
   logic [31:0] w_pad_mask;
   logic [31:0] w_cap_word;
   logic [2:0]  w_cap_nbytes;
   logic        w_cap_final;
   logic        w_hs;
   logic        w_more;
   logic [7:0]  w_next_byte;

   assign w_nbits      = (bus.in_last_bits == 5'd0) ? 6'd32 : {1'b0, bus.in_last_bits};
   assign w_nbits_rnd  = w_nbits + 6'd7;
   assign w_pad_mask   = 32'hFFFF_FFFF >> w_nbits;
   assign w_cap_word   = bus.in_last ? (bus.in_data | w_pad_mask) : bus.in_data;
   assign w_cap_nbytes = bus.in_last ? w_nbits_rnd[5:3] : 3'd4;
   assign w_cap_final  = bus.in_last && (w_cap_nbytes == 3'd1);

   assign w_hs        = r_out_valid && bus.out_ready;
   assign w_more      = (r_nbytes > 3'd1);
   assign w_next_byte = r_buf[23:16];

   // Byte-serialising state machine with registered stream outputs and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_buf        <= 32'd0;
         r_last       <= 1'b0;
         r_nbytes     <= 3'd0;
         r_in_ready   <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_data   <= 8'd0;
         r_out_last   <= 1'b0;
         r_cnt        <= '0;
         r_reload     <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_hs && r_out_last;

         // Byte counter: first byte after a finished frame restarts the count.
         if (w_hs) begin
            if (r_reload) begin
               r_cnt <= CNT_W'(1);
            end else if (r_cnt != {CNT_W{1'b1}}) begin
               r_cnt <= r_cnt + 1'b1;
            end
            r_reload <= r_out_last;
         end

         case (r_state)
            S_IDLE: begin
               if (bus.in_valid && r_in_ready) begin
                  r_buf       <= w_cap_word;
                  r_last      <= bus.in_last;
                  r_nbytes    <= w_cap_nbytes;
                  r_out_valid <= 1'b1;
                  r_out_data  <= w_cap_word[31:24];
                  r_out_last  <= !c_emit_eoi && w_cap_final && (w_cap_word[31:24] != 8'hFF);
                  r_in_ready  <= 1'b0;
                  r_state     <= S_DATA;
               end else begin
                  r_in_ready  <= 1'b1;
               end
            end

            // STUFF resumes exactly where DATA would have gone after the 0xFF.
            S_DATA, S_STUFF: begin
               if (w_hs) begin
                  if ((r_state == S_DATA) && (r_buf[31:24] == 8'hFF)) begin
                     r_out_data <= 8'h00;
                     r_out_last <= !c_emit_eoi && r_last && !w_more;
                     r_state    <= S_STUFF;
                  end else if (w_more) begin
                     r_buf      <= {r_buf[23:0], 8'h00};
                     r_nbytes   <= r_nbytes - 3'd1;
                     r_out_data <= w_next_byte;
                     r_out_last <= !c_emit_eoi && r_last && (r_nbytes == 3'd2) &&
                                   (w_next_byte != 8'hFF);
                     r_state    <= S_DATA;
                  end else if (r_last && c_emit_eoi) begin
                     r_out_data <= 8'hFF;
                     r_out_last <= 1'b0;
                     r_state    <= S_EOI_FF;
                  end else begin
                     r_out_valid <= 1'b0;
                     r_out_last  <= 1'b0;
                     r_in_ready  <= 1'b1;
                     r_state     <= S_IDLE;
                  end
               end
            end

            S_EOI_FF: begin
               if (w_hs) begin
                  r_out_data <= 8'hD9;
                  r_out_last <= 1'b1;
                  r_state    <= S_EOI_D9;
               end
            end

            S_EOI_D9: begin
               if (w_hs) begin
                  r_out_valid <= 1'b0;
                  r_out_last  <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end

            default: begin
               r_out_valid <= 1'b0;
               r_out_last  <= 1'b0;
               r_in_ready  <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_last  = r_out_last;
   assign byte_count    = r_cnt;
   assign frame_done    = r_frame_done;
   assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_jpeg_byte_stuffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jpeg_byte_stuffer
//  Description : Self-checking bench for jpeg_byte_stuffer. Instance 0 has
//                EOI insertion enabled and instance 1 has it disabled. The
//                byte stream is compared against a word-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_jpeg_byte_stuffer;
   localparam int CNT_W = 24;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_v       [2];
   logic             d_in_valid  [2];
   logic [31:0]      d_in_data   [2];
   logic             d_in_last   [2];
   logic [4:0]       d_in_bits   [2];
   logic             d_out_ready [2] = '{1'b0, 1'b0};
   logic             m_in_ready  [2];
   logic             m_out_valid [2];
   logic             m_out_last  [2];
   logic [7:0]       m_out_data  [2];
   logic             m_frame_done[2];
   logic             m_busy      [2];
   logic [CNT_W-1:0] m_cnt       [2];

   bit         rdy_rand[2];
   logic       rdy_fix [2];
   int         n_total = 0;
   int         n_bad   = 0;
   int         cyc     = 0;
   int         last_cap;
   logic [8:0] exp_q[$];
   logic [8:0] obs_q[$];
   int         obs_t[$];

   int         mdl_cnt    [2];
   bit         mdl_reload [2];
   bit         prev_stall [2];
   bit         prev_lasths[2];
   bit         first_cyc  [2];
   logic [8:0] prev_out   [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Downstream ready: random or fixed, applied shortly after each rising edge.
   always @(posedge clk) begin
      #2;
      for (int i = 0; i < 2; i++)
         d_out_ready[i] = rdy_rand[i] ? 1'($urandom_range(0, 1)) : rdy_fix[i];
   end

   generate
      for (genvar g = 0; g < 2; g++) begin : g_dut
         jpeg_byte_stuffer_if u_if ();
         assign u_if.in_valid     = d_in_valid[g];
         assign u_if.in_data      = d_in_data[g];
         assign u_if.in_last      = d_in_last[g];
         assign u_if.in_last_bits = d_in_bits[g];
         assign u_if.out_ready    = d_out_ready[g];
         assign m_in_ready[g]     = u_if.in_ready;
         assign m_out_valid[g]    = u_if.out_valid;
         assign m_out_data[g]     = u_if.out_data;
         assign m_out_last[g]     = u_if.out_last;

         jpeg_byte_stuffer #(
            .EMIT_EOI ((g == 0) ? 1 : 0),
            .CNT_W    (CNT_W)
         ) u_dut (
            .clk        (clk),
            .rst        (rst_v[g]),
            .bus        (u_if),
            .byte_count (m_cnt[g]),
            .frame_done (m_frame_done[g]),
            .busy       (m_busy[g])
         );

         // Monitor: collect accepted bytes, check hold, frame_done and byte count.
         always @(negedge clk) begin
            if (rst_v[g]) begin
               mdl_cnt[g]     = 0;
               mdl_reload[g]  = 1'b0;
               prev_stall[g]  = 1'b0;
               prev_lasths[g] = 1'b0;
               first_cyc[g]   = 1'b1;
            end else begin
               chk("byte_count", 32'(m_cnt[g]), 32'(mdl_cnt[g]));
               chk("frame_done", 32'(m_frame_done[g]), 32'(prev_lasths[g]));
               if (!first_cyc[g])
                  chk("in_ready_idle", 32'(m_in_ready[g]), 32'(!m_busy[g]));
               if (prev_stall[g]) begin
                  chk("hold_valid", 32'(m_out_valid[g]), 32'd1);
                  chk("hold_byte", 32'({m_out_last[g], m_out_data[g]}), 32'(prev_out[g]));
               end
               first_cyc[g]   = 1'b0;
               prev_stall[g]  = m_out_valid[g] && !d_out_ready[g];
               prev_out[g]    = {m_out_last[g], m_out_data[g]};
               prev_lasths[g] = m_out_valid[g] && d_out_ready[g] && m_out_last[g];
               if (m_out_valid[g] && d_out_ready[g]) begin
                  obs_q.push_back({m_out_last[g], m_out_data[g]});
                  obs_t.push_back(cyc);
                  if (mdl_reload[g])
                     mdl_cnt[g] = 1;
                  else if (mdl_cnt[g] < (1 << CNT_W) - 1)
                     mdl_cnt[g] = mdl_cnt[g] + 1;
                  mdl_reload[g] = m_out_last[g];
               end
            end
         end
      end
   endgenerate

   // Reference model: whole word in, expected {last, byte} sequence out.
   function automatic void mdl_push(input int w, input logic [31:0] data, input bit last,
                                    input logic [4:0] bits);
      int          n;
      int          nb;
      logic [31:0] v;
      logic [7:0]  b;
      logic [8:0]  tmp;
      n  = (bits == 5'd0) ? 32 : int'(bits);
      nb = last ? (n + 7) / 8 : 4;
      v  = data;
      if (last && n < 32) v = data | ((32'd1 << (32 - n)) - 32'd1);
      for (int i = 0; i < nb; i++) begin
         b = 8'(v >> (24 - 8 * i));
         exp_q.push_back({1'b0, b});
         if (b == 8'hFF) exp_q.push_back(9'h000);
      end
      if (last) begin
         if (w == 0) begin
            exp_q.push_back(9'h0FF);
            exp_q.push_back(9'h1D9);
         end else begin
            tmp = exp_q.pop_back();
            exp_q.push_back(tmp | 9'h100);
         end
      end
   endfunction

   function automatic logic [31:0] rand_word();
      logic [31:0] v;
      v = $urandom;
      for (int k = 0; k < 4; k++)
         if ($urandom_range(0, 3) == 0) v[8*k +: 8] = 8'hFF;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      exp_q.delete();
      obs_q.delete();
      obs_t.delete();
   endtask

   task automatic do_reset(input int w);
      rst_v[w] = 1'b1;
      tick();
      tick();
      rst_v[w] = 1'b0;
      tick();
      clear_q();
   endtask

   task automatic send_word(input int w, input logic [31:0] data, input bit last,
                            input logic [4:0] bits, input bit use_mdl);
      bit got;
      got = 1'b0;
      if (use_mdl) mdl_push(w, data, last, bits);
      d_in_valid[w] = 1'b1;
      d_in_data[w]  = data;
      d_in_last[w]  = last;
      d_in_bits[w]  = bits;
      for (int i = 0; i < 5000 && !got; i++) begin
         @(negedge clk);
         if (m_in_ready[w]) begin
            got      = 1'b1;
            last_cap = cyc;
         end
         @(posedge clk);
         #1;
      end
      d_in_valid[w] = 1'b0;
      chk("send_accept", 32'(got), 32'd1);
   endtask

   task automatic wait_drain(input int w);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 20000 && !done; i++) begin
         @(negedge clk);
         if (obs_q.size() >= exp_q.size() && !m_busy[w] && !m_out_valid[w]) done = 1'b1;
      end
      chk("drain", 32'(done), 32'd1);
      tick();
   endtask

   task automatic compare_streams(input string tag);
      chk({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         chk($sformatf("%s[%0d]", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
      clear_q();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         rst_v[i]      = 1'b1;
         d_in_valid[i] = 1'b0;
         d_in_data[i]  = 32'd0;
         d_in_last[i]  = 1'b0;
         d_in_bits[i]  = 5'd0;
         rdy_rand[i]   = 1'b0;
         rdy_fix[i]    = 1'b1;
      end

      // Reset state, during and just after reset.
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("rst_in_ready", 32'(m_in_ready[i]), 32'd0);
         chk("rst_out_valid", 32'(m_out_valid[i]), 32'd0);
         chk("rst_busy", 32'(m_busy[i]), 32'd0);
      end
      tick();
      rst_v[0] = 1'b0;
      rst_v[1] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("post_rst_in_ready", 32'(m_in_ready[i]), 32'd1);
         chk("post_rst_out", 32'({m_out_valid[i], m_out_last[i], m_out_data[i]}), 32'd0);
         chk("post_rst_cnt", 32'(m_cnt[i]), 32'd0);
         chk("post_rst_fd", 32'(m_frame_done[i]), 32'd0);
      end
      tick();

      // Plain word: four consecutive bytes, the first one a cycle after capture.
      exp_q = '{9'h012, 9'h034, 9'h056, 9'h078};
      send_word(0, 32'h1234_5678, 1'b0, 5'd0, 1'b0);
      wait_drain(0);
      chk("t1_latency", 32'(obs_t[0]), 32'(last_cap + 1));
      for (int i = 1; i < 4 && i < obs_t.size(); i++)
         chk("t1_back2back", 32'(obs_t[i]), 32'(obs_t[0] + i));
      chk("t1_count", 32'(m_cnt[0]), 32'd4);
      compare_streams("t1");

      // Stuffing after every 0xFF data byte.
      do_reset(0);
      exp_q = '{9'h0FF, 9'h000, 9'h000, 9'h0FF, 9'h000, 9'h0AB};
      send_word(0, 32'hFF00_FFAB, 1'b0, 5'd0, 1'b0);
      wait_drain(0);
      chk("t2_count", 32'(m_cnt[0]), 32'd6);
      compare_streams("t2");

      // Ten valid bits: 0xA5, then 11 + six pad ones = 0xFF (stuffed), then EOI.
      do_reset(0);
      exp_q = '{9'h0A5, 9'h0FF, 9'h000, 9'h0FF, 9'h1D9};
      send_word(0, 32'hA5C0_0000, 1'b1, 5'd10, 1'b0);
      wait_drain(0);
      chk("t3_count", 32'(m_cnt[0]), 32'd5);
      compare_streams("t3");

      // No EOI: last flag moves onto the stuff byte after a final 0xFF.
      do_reset(1);
      rdy_fix[1] = 1'b1;
      exp_q = '{9'h0FF, 9'h100};
      send_word(1, 32'hFF00_0000, 1'b1, 5'd8, 1'b0);
      wait_drain(1);
      chk("t4_count", 32'(m_cnt[1]), 32'd2);
      compare_streams("t4");

      // Random words, random back-pressure, both EOI settings.
      do_reset(0);
      rdy_rand[0] = 1'b1;
      for (int i = 0; i < 200; i++)
         send_word(0, rand_word(), (i == 199) || ($urandom_range(0, 7) == 0),
                   5'($urandom_range(0, 31)), 1'b1);
      wait_drain(0);
      compare_streams("rand_eoi");
      rdy_rand[0] = 1'b0;

      do_reset(1);
      rdy_rand[1] = 1'b1;
      for (int i = 0; i < 80; i++)
         send_word(1, rand_word(), (i == 79) || ($urandom_range(0, 5) == 0),
                   5'($urandom_range(0, 31)), 1'b1);
      wait_drain(1);
      compare_streams("rand_noeoi");
      rdy_rand[1] = 1'b0;

      // Reset while parked in the stuff byte, then a clean frame.
      do_reset(0);
      rdy_fix[0] = 1'b0;
      send_word(0, 32'hFF00_FFAB, 1'b0, 5'd0, 1'b0);
      rdy_fix[0] = 1'b1;
      tick();
      rdy_fix[0] = 1'b0;
      @(negedge clk);
      chk("t6_in_stuff", 32'({m_out_valid[0], m_out_data[0]}), 32'h100);
      tick();
      rst_v[0] = 1'b1;
      tick();
      rst_v[0] = 1'b0;
      @(negedge clk);
      chk("t6_valid", 32'(m_out_valid[0]), 32'd0);
      chk("t6_busy", 32'(m_busy[0]), 32'd0);
      chk("t6_count", 32'(m_cnt[0]), 32'd0);
      tick();
      clear_q();
      rdy_fix[0] = 1'b1;
      send_word(0, 32'h3CFF_1234, 1'b0, 5'd0, 1'b1);
      send_word(0, 32'hFFE0_0000, 1'b1, 5'd11, 1'b1);
      wait_drain(0);
      compare_streams("t6_frame");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
